// File: rtl/iterative_divider_if.sv
// Request/response bundle for iterative_divider: valid/ready request with tag,
// flush, and valid/ready result return.
interface iterative_divider_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             valid_i;
  logic             ready_o;
  logic [1:0]       op_i;
  logic [XLEN-1:0]  a_i;
  logic [XLEN-1:0]  b_i;
  logic [TAG_W-1:0] tag_i;
  logic             flush_i;
  logic             valid_o;
  logic             ready_i;
  logic [XLEN-1:0]  result_o;
  logic [TAG_W-1:0] tag_o;

  modport slave (
    input  valid_i, op_i, a_i, b_i, tag_i, flush_i, ready_i,
    output ready_o, valid_o, result_o, tag_o
  );

  modport master (
    output valid_i, op_i, a_i, b_i, tag_i, flush_i, ready_i,
    input  ready_o, valid_o, result_o, tag_o
  );
endinterface

// File: rtl/iterative_divider.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one step per cycle.
// Optional build macro DIV_EARLY_OUT_EN short-circuits /0, signed overflow and zero dividend.
module iterative_divider #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  iterative_divider_if.slave dif
);
  localparam int CNT_W = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_reg;
  logic             live_reg;
  logic [1:0]       op_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [XLEN-1:0]  a_reg;
  logic [XLEN-1:0]  b_reg;
  logic [XLEN-1:0]  dvd_reg;
  logic [XLEN-1:0]  dsr_reg;
  logic [XLEN-1:0]  quo_reg;
  logic [XLEN-1:0]  rem_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [XLEN-1:0]  result_reg;
  logic [TAG_W-1:0] tag_out_reg;
  logic             valid_reg;

  logic             accept;
  logic             in_signed;
  logic [XLEN-1:0]  a_mag;
  logic [XLEN-1:0]  b_mag;
  logic [XLEN:0]    partial;
  logic [XLEN:0]    diff;
  logic             step_ok;
  logic             fix_signed;
  logic [XLEN-1:0]  quo_fix;
  logic [XLEN-1:0]  rem_fix;
  logic [XLEN-1:0]  fix_result;

  // live_reg keeps ready_o low while reset is asserted and for the first edge after.
  assign dif.ready_o  = live_reg && (state_reg == IDLE) && !dif.flush_i;
  assign dif.valid_o  = valid_reg;
  assign dif.result_o = result_reg;
  assign dif.tag_o    = tag_out_reg;
  assign accept       = dif.valid_i && dif.ready_o;

  always_comb begin
    in_signed = !dif.op_i[0];
    a_mag     = (in_signed && dif.a_i[XLEN-1]) ? -dif.a_i : dif.a_i;
    b_mag     = (in_signed && dif.b_i[XLEN-1]) ? -dif.b_i : dif.b_i;
  end

  // Partial remainder is always below the divisor, so XLEN bits suffice between steps.
  always_comb begin
    partial = {rem_reg, dvd_reg[XLEN-1]};
    diff    = partial - {1'b0, dsr_reg};
    step_ok = !diff[XLEN];
  end

  always_comb begin
    fix_signed = !op_reg[0];
    quo_fix    = quo_reg;
    rem_fix    = rem_reg;
    if (b_reg == '0) begin
      quo_fix = '1;
      rem_fix = a_reg;
    end else begin
      if (fix_signed && (a_reg[XLEN-1] ^ b_reg[XLEN-1]))
        quo_fix = -quo_reg;
      if (fix_signed && a_reg[XLEN-1])
        rem_fix = -rem_reg;
    end
    fix_result = op_reg[1] ? rem_fix : quo_fix;
  end

`ifdef DIV_EARLY_OUT_EN
  logic            eo_hit;
  logic [XLEN-1:0] eo_result;

  always_comb begin
    eo_hit    = 1'b0;
    eo_result = '0;
    if (dif.b_i == '0) begin
      eo_hit    = 1'b1;
      eo_result = dif.op_i[1] ? dif.a_i : '1;
    end else if (in_signed && (dif.a_i == {1'b1, {(XLEN-1){1'b0}}}) && (dif.b_i == '1)) begin
      eo_hit    = 1'b1;
      eo_result = dif.op_i[1] ? '0 : dif.a_i;
    end else if (dif.a_i == '0) begin
      eo_hit    = 1'b1;
      eo_result = '0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      live_reg    <= 1'b0;
      op_reg      <= '0;
      tag_reg     <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      dvd_reg     <= '0;
      dsr_reg     <= '0;
      quo_reg     <= '0;
      rem_reg     <= '0;
      cnt_reg     <= '0;
      result_reg  <= '0;
      tag_out_reg <= '0;
      valid_reg   <= 1'b0;
    end else begin
      live_reg <= 1'b1;
      if (dif.flush_i) begin
        state_reg <= IDLE;
        valid_reg <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (accept) begin
              op_reg    <= dif.op_i;
              tag_reg   <= dif.tag_i;
              a_reg     <= dif.a_i;
              b_reg     <= dif.b_i;
              dvd_reg   <= a_mag;
              dsr_reg   <= b_mag;
              quo_reg   <= '0;
              rem_reg   <= '0;
              cnt_reg   <= CNT_W'(XLEN);
              state_reg <= CALC;
`ifdef DIV_EARLY_OUT_EN
              if (eo_hit) begin
                result_reg  <= eo_result;
                tag_out_reg <= dif.tag_i;
                valid_reg   <= 1'b1;
                state_reg   <= DONE;
              end
`endif
            end
          end
          CALC: begin
            rem_reg <= step_ok ? diff[XLEN-1:0] : partial[XLEN-1:0];
            quo_reg <= {quo_reg[XLEN-2:0], step_ok};
            dvd_reg <= {dvd_reg[XLEN-2:0], 1'b0};
            cnt_reg <= cnt_reg - 1'b1;
            if (cnt_reg == CNT_W'(1))
              state_reg <= FIX;
          end
          FIX: begin
            result_reg  <= fix_result;
            tag_out_reg <= tag_reg;
            valid_reg   <= 1'b1;
            state_reg   <= DONE;
          end
          DONE: begin
            if (dif.ready_i) begin
              valid_reg <= 1'b0;
              state_reg <= IDLE;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_iterative_divider.sv
// Scoreboard bench for iterative_divider: directed vectors queued at accept,
// checked by an independent monitor on each result handshake.
module tb_iterative_divider;
  localparam int XLEN = 32;
  localparam int TAG_W = 5;
`ifdef DIV_EARLY_OUT_EN
  localparam int LAT_EO = 1;
`else
  localparam int LAT_EO = 34;
`endif
  localparam int LAT = 34;
  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  typedef struct {
    logic [XLEN-1:0]  res;
    logic [TAG_W-1:0] tag;
    int               lat;
    int               acc;
  } exp_t;
  exp_t sb[$];

  iterative_divider_if #(.XLEN(XLEN), .TAG_W(TAG_W)) dif ();

  iterative_divider #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .dif  (dif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: latency check on first valid, value check on handshake.
  bit valid_seen = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      valid_seen = 0;
    end else if (dif.valid_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'(dif.valid_o), 32'd0);
      end else begin
        if (!valid_seen) begin
          chk("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
          valid_seen = 1;
        end
        if (dif.ready_i) begin
          exp_t e;
          e = sb.pop_front();
          chk("result", dif.result_o, e.res);
          chk("tag", 32'(dif.tag_o), 32'(e.tag));
          $display("txn tag=%0d result=0x%08h expected=0x%08h", dif.tag_o, dif.result_o, e.res);
          valid_seen = 0;
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] exp, input int lat,
                       input bit push);
    exp_t e;
    bit   got;
    @(posedge clk); #1;
    dif.valid_i = 1'b1;
    dif.op_i    = op;
    dif.a_i     = a;
    dif.b_i     = b;
    dif.tag_i   = tag;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dif.ready_o) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else if (push) begin
      e.res = exp; e.tag = tag; e.lat = lat; e.acc = cyc;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    dif.valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic run(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                     input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] exp, input int lat);
    issue(op, a, b, tag, exp, lat, 1);
    wait_drain();
  endtask

  initial begin
    bit any_valid;
    dif.valid_i = 0; dif.op_i = 0; dif.a_i = 0; dif.b_i = 0; dif.tag_i = 0;
    dif.flush_i = 0; dif.ready_i = 1;

    @(negedge clk);
    chk("rst_valid", 32'(dif.valid_o), 32'd0);
    chk("rst_ready", 32'(dif.ready_o), 32'd0);
    chk("rst_result", dif.result_o, 32'd0);
    chk("rst_tag", 32'(dif.tag_o), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run(OP_DIVU, 32'd100, 32'd7, 5'd3, 32'd14, LAT);
    run(OP_REMU, 32'd100, 32'd7, 5'd1, 32'd2, LAT);
    run(OP_DIV, 32'hFFFFFFF9, 32'd2, 5'd7, 32'hFFFFFFFD, LAT);
    run(OP_REM, 32'hFFFFFFF9, 32'd2, 5'd8, 32'hFFFFFFFF, LAT);
    run(OP_DIV, 32'd7, 32'hFFFFFFFE, 5'd10, 32'hFFFFFFFD, LAT);
    run(OP_REM, 32'd7, 32'hFFFFFFFE, 5'd11, 32'd1, LAT);
    run(OP_DIVU, 32'hFFFFFFFF, 32'd1, 5'd12, 32'hFFFFFFFF, LAT);
    run(OP_REMU, 32'hFFFFFFFF, 32'h10, 5'd13, 32'hF, LAT);
    run(OP_DIV, 32'd5, 32'd0, 5'd14, 32'hFFFFFFFF, LAT_EO);
    run(OP_REM, 32'd5, 32'd0, 5'd15, 32'd5, LAT_EO);
    run(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000, LAT_EO);
    run(OP_REM, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'd0, LAT_EO);
    run(OP_DIVU, 32'd0, 32'd5, 5'd18, 32'd0, LAT_EO);

    // Backpressure: hold ready_i low for 10 cycles once the result is up.
    dif.ready_i = 1'b0;
    issue(OP_DIVU, 32'd100, 32'd7, 5'd9, 32'd14, LAT, 1);
    any_valid = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (dif.valid_o) begin
        any_valid = 1;
        break;
      end
    end
    chk("hold_valid_seen", 32'(any_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("hold_result", dif.result_o, 32'd14);
      chk("hold_tag", 32'(dif.tag_o), 32'd9);
      chk("hold_ready", 32'(dif.ready_o), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1 dif.ready_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post_hs_ready", 32'(dif.ready_o), 32'd1);
    chk("post_hs_valid", 32'(dif.valid_o), 32'd0);
    chk("post_hs_drained", 32'(sb.size()), 32'd0);

    // Flush at CALC step 10.
    issue(OP_DIVU, 32'd100, 32'd7, 5'd20, 32'd0, LAT, 0);
    repeat (9) @(posedge clk);
    #1 dif.flush_i = 1'b1;
    @(posedge clk); #1 dif.flush_i = 1'b0;
    @(negedge clk);
    chk("flush_ready", 32'(dif.ready_o), 32'd1);
    chk("flush_valid", 32'(dif.valid_o), 32'd0);
    any_valid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dif.valid_o) any_valid = 1;
    end
    chk("flush_no_valid", 32'(any_valid), 32'd0);
    run(OP_DIVU, 32'd9, 32'd3, 5'd4, 32'd3, LAT);

    // Reset at CALC step 10.
    issue(OP_DIVU, 32'd100, 32'd7, 5'd21, 32'd0, LAT, 0);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_valid", 32'(dif.valid_o), 32'd0);
    chk("mrst_ready", 32'(dif.ready_o), 32'd0);
    chk("mrst_result", dif.result_o, 32'd0);
    chk("mrst_tag", 32'(dif.tag_o), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run(OP_DIVU, 32'd9, 32'd3, 5'd6, 32'd3, LAT);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
